// File: rtl/mod_addsub_sequencer.sv
// Sequencer around a combinational 4-bit modular adder/subtractor core.
// Commands are queued in a small FIFO, issued one per cycle from a register
// that drives the core, and the core result is captured into a result stage
// with a valid/ready handshake and a running sequence tag.
module mod_addsub_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  logic                   cmd_s,
  input  logic [3:0]             cmd_x,
  input  logic [3:0]             cmd_y,
  output logic                   core_s,
  output logic [3:0]             core_x,
  output logic [3:0]             core_y,
  input  logic [3:0]             core_z,
  output logic                   res_vld,
  input  logic                   res_rdy,
  output logic [3:0]             res_z,
  output logic                   res_s,
  output logic [SEQ_W-1:0]       res_seq,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // FIFO entry layout: {s, x[3:0], y[3:0]}
  logic [8:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             iss_vld_q, iss_vld_d;
  logic [8:0]       iss_q, iss_d;
  logic             res_vld_q, res_vld_d;
  logic [3:0]       res_z_q, res_z_d;
  logic             res_s_q, res_s_d;
  logic [SEQ_W-1:0] res_seq_q, res_seq_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  logic push, res_load, iss_load;

  // Handshake and pipeline advance conditions; no full-FIFO bypass on pop.
  always_comb begin
    cmd_rdy  = rst_n & (cnt_q < CW'(DEPTH));
    push     = cmd_vld & cmd_rdy & ~flush;
    res_load = iss_vld_q & (~res_vld_q | res_rdy);
    iss_load = (cnt_q != '0) & (~iss_vld_q | res_load);
  end

  // Next-state for FIFO pointers, issue and result stages; flush wins.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    iss_vld_d = iss_vld_q;
    iss_d     = iss_q;
    res_vld_d = res_vld_q;
    res_z_d   = res_z_q;
    res_s_d   = res_s_q;
    res_seq_d = res_seq_q;
    seq_d     = seq_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (iss_load) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !iss_load) cnt_d = cnt_q + CW'(1);
    else if (!push && iss_load) cnt_d = cnt_q - CW'(1);

    if (iss_load) begin
      iss_d     = mem_q[rd_ptr_q];
      iss_vld_d = 1'b1;
    end else if (res_load) begin
      iss_vld_d = 1'b0;
    end

    // core_z is only looked at here, so X on it elsewhere stays contained.
    if (res_load) begin
      res_z_d   = core_z;
      res_s_d   = iss_q[8];
      res_seq_d = seq_q;
      seq_d     = seq_q + SEQ_W'(1);
      res_vld_d = 1'b1;
    end else if (res_vld_q && res_rdy) begin
      res_vld_d = 1'b0;
    end

    // Issue register contents are kept across a flush.
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      iss_vld_d = 1'b0;
      iss_d     = iss_q;
      res_vld_d = 1'b0;
      res_z_d   = res_z_q;
      res_s_d   = res_s_q;
      res_seq_d = res_seq_q;
      seq_d     = '0;
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
      res_vld_q <= 1'b0;
      res_z_q   <= '0;
      res_s_q   <= 1'b0;
      res_seq_q <= '0;
      seq_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
      res_vld_q <= res_vld_d;
      res_z_q   <= res_z_d;
      res_s_q   <= res_s_d;
      res_seq_q <= res_seq_d;
      seq_q     <= seq_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_s, cmd_x, cmd_y};
  end

  // Output mapping.
  always_comb begin
    core_s   = iss_q[8];
    core_x   = iss_q[7:4];
    core_y   = iss_q[3:0];
    res_vld  = res_vld_q;
    res_z    = res_z_q;
    res_s    = res_s_q;
    res_seq  = res_seq_q;
    fifo_cnt = cnt_q;
  end

endmodule
